// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  localparam int DEF_NO_OF_REG = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_WIDTH     = 32;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every register to zero after reset or on clr_req.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NO_OF_REG = DEF_NO_OF_REG,
  parameter int AW        = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (clr_req) state_d = CLEAR;
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NO_OF_REG - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero register and clear sequencer.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NO_OF_REG         = DEF_NO_OF_REG,
  parameter int REG_ADDRESS_WIDTH = DEF_ADDR_W,
  parameter int WIDTH             = DEF_WIDTH,
  parameter int NUM_RD            = 2,
  parameter int NUM_WR            = 1,
  parameter int ZERO_REG          = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr_req,
  output logic                                busy,
  input  logic [NUM_WR-1:0]                   we,
  input  logic [NUM_WR*REG_ADDRESS_WIDTH-1:0] wa,
  input  logic [NUM_WR*WIDTH-1:0]             wd,
  input  logic [NUM_RD*REG_ADDRESS_WIDTH-1:0] ra,
  output logic [NUM_RD*WIDTH-1:0]             rd
);

  localparam int AW = REG_ADDRESS_WIDTH;

  logic [WIDTH-1:0] mem [NO_OF_REG];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;

  regfile_clear_seq #(.NO_OF_REG(NO_OF_REG), .AW(AW)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Higher port index is applied last, so port 1 wins an address conflict.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++)
        if (we[i] && !(ZERO_REG != 0 && wa[i*AW +: AW] == '0))
          mem[wa[i*AW +: AW]] <= wd[i*WIDTH +: WIDTH];
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] val;

    assign addr = ra[j*AW +: AW];

    always_comb begin
      val = mem[addr];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++)
        if (we[i] && wa[i*AW +: AW] == addr) val = wd[i*WIDTH +: WIDTH];
`endif
      // Busy gating and the zero register override any bypassed data.
      if (busy || (ZERO_REG != 0 && addr == '0)) val = '0;
    end

    assign rd[j*WIDTH +: WIDTH] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (NUM_WR = 2, NUM_RD = 2).
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr_req = 1'b0;
  logic          busy;
  logic [1:0]    we = '0;
  logic [2*AW-1:0] wa = '0;
  logic [2*W-1:0]  wd = '0;
  logic [2*AW-1:0] ra = '0;
  logic [2*W-1:0]  rd;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp #(
    .NO_OF_REG(32), .REG_ADDRESS_WIDTH(AW), .WIDTH(W),
    .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count edges until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 32; r++) begin
      ra[AW-1:0]  = AW'(r);
      ra[2*AW-1:AW] = AW'(31 - r);
      #1;
      chk(tag, rd[W-1:0], 32'h0);
      chk(tag, rd[2*W-1:W], 32'h0);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    ra = {AW'(3), AW'(5)};
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_rd0", rd[W-1:0], 32'h0);
    chk("rst_rd1", rd[2*W-1:W], 32'h0);

    // Reset release: busy for exactly 32 edges
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_busy", {31'b0, busy}, 32'h1);
    wait_idle(cnt);
    chk("rel_busy_cycles", 32'(cnt), 32'd32);
    check_all_zero("rel_all_zero");

    // Write REG[5], read same cycle and next
    we = 2'b01; wa[AW-1:0] = 5'd5; wd[W-1:0] = 32'hDEADBEEF; ra[AW-1:0] = 5'd5;
    #1 chk("wr5_same", rd[W-1:0], BYP ? 32'hDEADBEEF : 32'h0);
    step();
    we = 2'b00;
    #1 chk("wr5_next", rd[W-1:0], 32'hDEADBEEF);

    // Zero register ignores writes
    we = 2'b01; wa[AW-1:0] = 5'd0; wd[W-1:0] = 32'hFFFFFFFF; ra[AW-1:0] = 5'd0;
    #1 chk("wr0_same", rd[W-1:0], 32'h0);
    step();
    we = 2'b00;
    #1 chk("wr0_next", rd[W-1:0], 32'h0);
    step();
    #1 chk("wr0_later", rd[W-1:0], 32'h0);

    // Both ports write address 7: port 1 wins
    we = 2'b11; wa = {AW'(7), AW'(7)}; wd = {32'h22222222, 32'h11111111}; ra = {AW'(7), AW'(7)};
    #1 chk("conf_same", rd[2*W-1:W], BYP ? 32'h22222222 : 32'h0);
    step();
    we = 2'b00;
    #1 chk("conf_next0", rd[W-1:0], 32'h22222222);
    chk("conf_next1", rd[2*W-1:W], 32'h22222222);

    // Two ports to distinct addresses
    we = 2'b11; wa = {AW'(10), AW'(9)}; wd = {32'hBBBB000A, 32'hAAAA0009};
    step();
    we = 2'b00; ra = {AW'(9), AW'(10)};
    #1 chk("dual_rd0", rd[W-1:0], 32'hBBBB000A);
    chk("dual_rd1", rd[2*W-1:W], 32'hAAAA0009);

    // Fill 1..31
    for (int r = 1; r < 32; r++) begin
      we = 2'b01; wa[AW-1:0] = AW'(r); wd[W-1:0] = 32'hA0000000 | 32'(r);
      step();
    end
    we = 2'b00; ra = {AW'(3), AW'(31)};
    #1 chk("fill_31", rd[W-1:0], 32'hA000001F);
    chk("fill_3", rd[2*W-1:W], 32'hA0000003);

    // clr_req sweep with ignored write and ignored re-request
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    #1 chk("clr_busy", {31'b0, busy}, 32'h1);
    ra = {AW'(25), AW'(20)};
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == 2) begin
        #1 chk("clr_gate_rd0", rd[W-1:0], 32'h0);
        chk("clr_gate_rd1", rd[2*W-1:W], 32'h0);
      end
      clr_req = (cnt == 5);
      if (cnt == 20) begin
        we = 2'b01; wa[AW-1:0] = 5'd3; wd[W-1:0] = 32'h33333333;
      end else begin
        we = 2'b00;
      end
      step();
      cnt++;
    end
    clr_req = 1'b0; we = 2'b00;
    chk("clr_busy_cycles", 32'(cnt), 32'd32);
    check_all_zero("clr_all_zero");

    // Reset mid-clear restarts the sweep
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    #1 chk("mid_rst_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(cnt);
    chk("mid_rst_cycles", 32'(cnt), 32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 32-bit MIPS datapath, successor to the single-write, dual-read file. It adds configurable read and write port counts and a hardwired zero register. An FSM-driven clear sequencer zeroes the array after reset or on request. Optional write-to-read bypass removes the one-cycle write-visibility gap for the forwarding unit. It sits between decode (read addresses) and writeback (write ports).

## Interface
- NO_OF_REG, 32, number of registers, power of two, ≥4
- REG_ADDRESS_WIDTH, 5, log2(NO_OF_REG)
- WIDTH, 32, data width
- NUM_RD, 2, read ports, 1–4
- NUM_WR, 1, write ports, 1–2
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clr_req  in  1  request full-array clear, sampled when idle
- busy  out  1  high while the clear sequence runs
- we  in  NUM_WR  per-port write enable
- wa  in  NUM_WR*REG_ADDRESS_WIDTH  packed write addresses; port i is slice i
- wd  in  NUM_WR*WIDTH  packed write data
- ra  in  NUM_RD*REG_ADDRESS_WIDTH  packed read addresses
- rd  out  NUM_RD*WIDTH  packed read data, combinational

## Operation
- FSM states are IDLE and CLEAR. The clear counter clr_cnt is REG_ADDRESS_WIDTH bits wide.
- Reset asserted: state = CLEAR, clr_cnt = 0, busy = 1. The array contents are not reset directly.
- In CLEAR, each cycle:
  - REG[clr_cnt] is written with 0 and clr_cnt increments.
  - When clr_cnt == NO_OF_REG-1, the cycle clears the last entry, then the FSM goes to IDLE and clr_cnt wraps to 0.
- IDLE with clr_req = 1: go to CLEAR next cycle. clr_req is ignored while in CLEAR.
- While busy:
  - All we are ignored.
  - All rd read 0.
- Write in IDLE: for each port i with we[i] = 1, REG[wa_i] <= wd_i at the rising edge.
- Write conflict, with NUM_WR = 2 and equal addresses both enabled: port 1 wins.
- Zero register, when ZERO_REG = 1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
- Read: rd_j = REG[ra_j], combinational (read-first). Without bypass, a write is visible on rd from the cycle after its edge.
- Reset mid-clear: the sequence restarts from clr_cnt = 0.

## Timing
- After rst_n deasserts, busy stays high for exactly NO_OF_REG rising edges, then falls. For example, 32 cycles at the default size.
- clr_req high in IDLE at edge N:
  - busy is high from after edge N.
  - busy is low after edge N+NO_OF_REG.
- Write latency is 1 cycle without bypass, 0 cycles with bypass.
- Reset values:
  - busy = 1.
  - rd = 0, from the busy gating.
- Combinational path: ra/wa/wd to rd. No registered outputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If any enabled write port in IDLE matches ra_j, rd_j returns that port's wd the same cycle.
  - When both ports match, port 1's data is returned.
  - The zero register and busy rules still take priority.
- REGFILE_BYPASS_EN undefined: pure read-first behaviour, with no wd-to-rd path.

## Structure
- Package regfile_pkg:
  - FSM state enum (IDLE, CLEAR).
  - Default localparams for width, depth and address width.
- Sub-module regfile_clear_seq holds the FSM and clr_cnt. It outputs busy, a clear write enable and the clear address.
- The top level holds the array, the write arbitration, the read muxes and the bypass.

## Test plan
- Reset release: busy high for 32 cycles. All rd = 0 during that time and all entries read 0 afterwards.
- Write REG[5] = 0xDEADBEEF with ra0 = 5 in the same cycle: rd0 is the old value (0) that cycle and 0xDEADBEEF next cycle. With REGFILE_BYPASS_EN, rd0 = 0xDEADBEEF in the same cycle.
- Write address 0 with 0xFFFFFFFF: rd reads 0 in all later cycles. With bypass enabled it also reads 0 in the same cycle.
- NUM_WR = 2, both ports write address 7 (0x11111111 on port 0, 0x22222222 on port 1): REG[7] reads 0x22222222.
- Fill registers 1–31 with nonzero data, then pulse clr_req:
  - busy is high for 32 cycles.
  - A write to REG[3] issued mid-clear is ignored.
  - All registers read 0 at the end.
- Assert rst_n low at clear cycle 10 and release it: busy stays high for a further 32 cycles, counted from the release.
